barrel_shift_pipe: RTL and testbench

Parametrised, pipelined barrel shifter with three shift modes: rotate, logical shift and arithmetic shift. Shift direction and amount are selected per operand. It is the streaming, width-generic successor to the 8-bit combinational rotator. Operands enter through a valid/ready handshake, pass through one register stage per shift-amount bit, and leave through a valid/ready handshake with full backpressure. It sits between a producer such as a datapath or ALU stage and any consumer that may stall.

---
 rtl/barrel_shift_pipe.sv | 134 +++++++++++++
 tb/tb_barrel_shift_pipe.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/barrel_shift_pipe.sv
// barrel_shift_pipe
//   Streaming barrel shifter: rotate, logical shift or arithmetic shift,
//   left or right, by 0..WIDTH-1 bit positions. One register stage per
//   shift-amount bit. Stage k shifts by 2^k when its amount bit is set.
//   A single advance enable moves the whole pipeline, so a stalled output
//   freezes every stage.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   operand present
//   in_ready   operand accepted this cycle (combinational from out_ready)
//   in_data    operand, WIDTH bits
//   in_sha     shift amount, SHA_W bits
//   in_lr      direction: 0 = left, 1 = right
//   in_mode    00 rotate, 01 logical, 10 arithmetic, 11 logical
//   out_valid  result present (registered)
//   out_ready  consumer accepts result
//   out_data   shifted result (registered)

module barrel_shift_pipe #(
  parameter int WIDTH = 8,
  parameter int SHA_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHA_W-1:0] in_sha,
  input  logic             in_lr,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic w_adv;

  assign w_adv    = ~out_valid | out_ready;
  assign in_ready = w_adv;

  for (genvar k = 0; k < SHA_W; k++) begin : g_stage
    // RW: shift-amount bits still to be applied at this stage (bit 0 is ours).
    localparam int RW = SHA_W - k;
    localparam int SH = 1 << k;
    // Bits vacated by a right shift of SH positions.
    localparam logic [WIDTH-1:0] FILL_MASK = ~({WIDTH{1'b1}} >> SH);

    logic [WIDTH-1:0] w_d;
    logic [RW-1:0]    w_sha;
    logic             w_lr;
    logic [1:0]       w_mode;
    logic             w_sign;
    logic             w_vld;
    logic [WIDTH-1:0] w_shifted;

    logic [WIDTH-1:0] r_data;
    logic             r_vld;

    if (k == 0) begin : g_src
      assign w_d    = in_data;
      assign w_sha  = in_sha;
      assign w_lr   = in_lr;
      assign w_mode = in_mode;
      // Sign is taken from the original operand so later stages still fill
      // correctly after earlier stages have moved bits around.
      assign w_sign = in_data[WIDTH-1];
      assign w_vld  = in_valid;
    end else begin : g_src
      assign w_d    = g_stage[k-1].r_data;
      assign w_sha  = g_stage[k-1].g_ctl.r_sha;
      assign w_lr   = g_stage[k-1].g_ctl.r_lr;
      assign w_mode = g_stage[k-1].g_ctl.r_mode;
      assign w_sign = g_stage[k-1].g_ctl.r_sign;
      assign w_vld  = g_stage[k-1].r_vld;
    end

    always_comb begin
      w_shifted = w_d;
      if (w_sha[0]) begin
        if (w_mode == 2'b00) begin
          w_shifted = w_lr ? ((w_d >> SH) | (w_d << (WIDTH - SH)))
                           : ((w_d << SH) | (w_d >> (WIDTH - SH)));
        end else if (w_lr) begin
          w_shifted = w_d >> SH;
          if (w_mode == 2'b10 && w_sign) begin
            w_shifted = w_shifted | FILL_MASK;
          end
        end else begin
          // Arithmetic left is the same as logical left.
          w_shifted = w_d << SH;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        r_data <= '0;
        r_vld  <= 1'b0;
      end else if (w_adv) begin
        r_data <= w_shifted;
        r_vld  <= w_vld;
      end
    end

    // Control travels with the data except out of the last stage, which has
    // nobody downstream to consume it.
    if (k < SHA_W - 1) begin : g_ctl
      logic [RW-2:0] r_sha;
      logic          r_lr;
      logic [1:0]    r_mode;
      logic          r_sign;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_sha  <= '0;
          r_lr   <= 1'b0;
          r_mode <= 2'b00;
          r_sign <= 1'b0;
        end else if (w_adv) begin
          r_sha  <= w_sha[RW-1:1];
          r_lr   <= w_lr;
          r_mode <= w_mode;
          r_sign <= w_sign;
        end
      end
    end
  end

  assign out_valid = g_stage[SHA_W-1].r_vld;
  assign out_data  = g_stage[SHA_W-1].r_data;

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Testbench for barrel_shift_pipe, WIDTH = 8.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. A driver pushes expected results into a queue on acceptance;
// a free-running monitor pops and compares whenever a result is transferred.

module tb_barrel_shift_pipe;

  localparam int W  = 8;
  localparam int SW = 3;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [SW-1:0] in_sha;
  logic          in_lr;
  logic [1:0]    in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [W-1:0]  exp_q[$];
  logic          prev_stall = 1'b0;
  logic [W-1:0]  prev_data  = '0;
  logic          rnd_phase  = 1'b0;

  barrel_shift_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sha    (in_sha),
    .in_lr     (in_lr),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference model written bit by bit, independent of the stage structure.
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input int n,
                                         input logic lr, input logic [1:0] m);
    logic [W-1:0] r;
    int src;
    r = '0;
    for (int i = 0; i < W; i++) begin
      if (lr) begin
        src = i + n;
        if (src < W)          r[i] = d[src];
        else if (m == 2'b00)  r[i] = d[src - W];
        else if (m == 2'b10)  r[i] = d[W-1];
        else                  r[i] = 1'b0;
      end else begin
        src = i - n;
        if (src >= 0)         r[i] = d[src];
        else if (m == 2'b00)  r[i] = d[src + W];
        else                  r[i] = 1'b0;
      end
    end
    return r;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [W-1:0] d, input int sha, input logic lr,
                      input logic [1:0] m, input logic [W-1:0] exp);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_sha   = SW'(sha);
    in_lr    = lr;
    in_mode  = m;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(exp);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 for 50 cycles expected 1");
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 100) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  // Monitor: scoreboard compare and stall-hold check.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) chk("stall_hold", {out_valid, out_data}, {1'b1, prev_data});
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_output: got %h expected none", out_data);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", out_data, e);
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
      end
    end
  end

  initial begin
    int n;
    logic [W-1:0] d;
    int sh;
    logic lr;
    logic [1:0] m;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sha    = '0;
    in_lr     = 1'b0;
    in_mode   = 2'b00;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 8'h00);
    chk("reset_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Latency: rotate right 0x96 by 3 -> 0xD2, valid 2 edges after acceptance.
    send(8'h96, 3, 1'b1, 2'b00, 8'hD2);
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency_edges", n, 2);
    @(posedge clk);
    #1;
    drain();

    // Directed vectors, back to back.
    send(8'h96, 2, 1'b0, 2'b01, 8'h58);
    send(8'h96, 3, 1'b1, 2'b10, 8'hF2);
    send(8'h96, 3, 1'b1, 2'b01, 8'h12);
    send(8'h96, 3, 1'b1, 2'b11, 8'h12);
    send(8'h96, 3, 1'b0, 2'b00, 8'hB4);
    send(8'h96, 1, 1'b0, 2'b10, 8'h2C);
    send(8'h96, 7, 1'b1, 2'b01, 8'h01);
    send(8'h96, 7, 1'b1, 2'b10, 8'hFF);
    send(8'h7F, 7, 1'b1, 2'b10, 8'h00);
    send(8'h96, 7, 1'b1, 2'b00, 8'h2D);
    send(8'h96, 4, 1'b0, 2'b11, 8'h60);
    for (int mm = 0; mm < 4; mm++) begin
      send(8'h96, 0, 1'b0, 2'(mm), 8'h96);
      send(8'h96, 0, 1'b1, 2'(mm), 8'h96);
    end
    drain();

    // Backpressure: stream 0x01..0x08 rotate left 1; stall cycles 4..7.
    fork
      begin
        for (int i = 1; i <= 8; i++) send(8'(i), 1, 1'b0, 2'b00, 8'(i << 1));
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          chk("stall_valid", out_valid, 1);
          chk("stall_data", out_data, 8'h02);
          chk("stall_in_ready", in_ready, 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two operands in flight.
    send(8'h11, 1, 1'b0, 2'b00, 8'h22);
    send(8'h33, 1, 1'b0, 2'b00, 8'h66);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_out_data", out_data, 8'h00);
    @(posedge clk);
    #1;
    idle(5);
    send(8'h80, 7, 1'b1, 2'b10, 8'hFF);
    drain();

    // Random operands, gaps and output stalls against the model.
    rnd_phase = 1'b1;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          idle($urandom_range(0, 2));
          d  = 8'($urandom);
          sh = $urandom_range(0, 7);
          lr = 1'($urandom_range(0, 1));
          m  = 2'($urandom_range(0, 3));
          send(d, sh, lr, m, model(d, sh, lr, m));
        end
        rnd_phase = 1'b0;
      end
      begin
        forever begin
          @(posedge clk);
          #1;
          if (!rnd_phase) break;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();
    idle(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
